// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one uart_out transmitter among N byte requesters. A round-robin
//   arbiter picks one requester per frame, registers its byte, pulses
//   tx_start for one cycle and then holds off further grants until the frame
//   plus the inter-frame gap has left the line. Clocked by the bit-rate clock
//   (one cycle per UART bit).
//
// Ports
//   clk        in   bit-rate clock
//   rst_n      in   asynchronous active-low reset
//   en         in   grant enable, sampled only while idle
//   req        in   [N]   per-requester level request, held until ack
//   req_data   in   [8N]  byte of requester i on bits [8i+7:8i]
//   ack        out  [N]   one-cycle pulse to the granted requester
//   tx_data    out  [8]   byte for uart_out, stable for the whole frame
//   tx_start   out        one-cycle start pulse for uart_out
//   busy       out        high while a frame or its gap is in progress
//   last_grant out  [3]   index of the most recently granted requester
//   dbg_state  out        current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a requester raises req[i] with req_data stable; the block
// answers with a single-cycle ack[i] on the grant edge. Requests seen while
// busy are ignored (not latched); a req still high on the next idle cycle is
// treated as a fresh request.
//
// A reset during a frame clears the outputs immediately, so the transmitter
// may emit a truncated frame; that is accepted behaviour.
module uart_tx_scheduler #(
  parameter int N          = 2,
  parameter int FRAME_BITS = 11,
  parameter int GAP_BITS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     ack,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic             busy,
  output logic [2:0]       last_grant,
  output logic             dbg_state
);

  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int TOTAL = FRAME_BITS + GAP_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  // Loaded on the grant edge; the BUSY state then lasts TOTAL cycles
  // (count TOTAL-1 down to 0, plus the cycle that sees zero).
  localparam logic [CW-1:0] CNT_LOAD = CW'(TOTAL - 1);
  localparam logic [PW-1:0] PTR_RST  = PW'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic [2:0]      last_grant_q, last_grant_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [7:0]      req_bytes [N];

  for (genvar g = 0; g < N; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin pick: first set request scanning cyclically from ptr+1.
  // j stays below N, so out-of-range indices are never produced.
  always_comb begin : pick
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!win_found && req[PW'(j)]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    ack_d        = '0;
    tx_start_d   = 1'b0;
    busy_d       = busy_q;
    tx_data_d    = tx_data_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (en && win_found) begin
          state_d          = S_BUSY;
          cnt_d            = CNT_LOAD;
          ptr_d            = win_idx;
          ack_d[win_idx]   = 1'b1;
          tx_start_d       = 1'b1;
          busy_d           = 1'b1;
          tx_data_d        = req_bytes[win_idx];
          last_grant_d     = 3'(win_idx);
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ptr_q        <= PTR_RST;
      ack_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      ack_q        <= ack_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ack        = ack_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a table of single-grant vectors, hand
// sequences for reset, contention, withdrawal, enable and a 3-requester
// instance, then randomized traffic against a cycle-level reference model.
module tb_uart_tx_scheduler;

  localparam int N  = 2;
  localparam int FB = 11;
  localparam int GB = 1;
  localparam int W  = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A (defaults)
  logic           en;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [7:0]     tx_data;
  logic           tx_start, busy, dbg_state;
  logic [2:0]     last_grant;

  // DUT B (N=3, FRAME_BITS=10, GAP_BITS=2)
  logic           en_b;
  logic [2:0]     req_b;
  logic [23:0]    req_data_b;
  logic [2:0]     ack_b;
  logic [7:0]     tx_data_b;
  logic           tx_start_b, busy_b, dbg_state_b;
  logic [2:0]     last_grant_b;

  uart_tx_scheduler #(.N(N), .FRAME_BITS(FB), .GAP_BITS(GB)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_data(req_data),
    .ack(ack), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
    .last_grant(last_grant), .dbg_state(dbg_state)
  );

  uart_tx_scheduler #(.N(3), .FRAME_BITS(10), .GAP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b), .req_data(req_data_b),
    .ack(ack_b), .tx_data(tx_data_b), .tx_start(tx_start_b), .busy(busy_b),
    .last_grant(last_grant_b), .dbg_state(dbg_state_b)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; req = '0; req_data = '0;
    en_b = 1'b0; req_b = '0; req_data_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check(name, busy, 0);
  endtask

  // reference model: a grant takes FB+GB cycles off the line, then the
  // next idle cycle may grant again; winner = first request after pointer.
  int         m_ptr, m_left, m_lg;
  logic [7:0] m_data;
  logic [1:0] m_ack;
  logic       m_start;

  task automatic model_init();
    m_ptr = N - 1; m_left = 0; m_lg = 0; m_data = 8'h00;
  endtask

  task automatic model_step();
    m_ack = '0; m_start = 1'b0;
    if (m_left > 0) m_left--;
    else if (en && req != '0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req[j]) begin
          m_ack = 2'(1 << j); m_start = 1'b1;
          m_data = req_data[8*j +: 8];
          m_lg = j; m_ptr = j; m_left = FB + GB;
          break;
        end
      end
    end
    exp_q.push_back({m_ack, m_start, (m_left != 0), m_data, 3'(m_lg)});
  endtask

  typedef struct {
    logic       en;
    logic [1:0] req;
    logic [7:0] d0, d1;
    logic [1:0] e_ack;
    logic       e_start;
    logic [7:0] e_data;
    logic       e_busy;
    logic [2:0] e_lg;
  } vec_t;
  vec_t vecs[8];

  int st[4];
  logic [7:0] dt[4];
  logic [2:0] ak[4];
  int n, c0, a1, last_st, since, bc, cnt;
  logic [W-1:0] e;

  initial begin
    en = 1'b0; req = '0; req_data = '0;
    en_b = 1'b0; req_b = '0; req_data_b = '0;

    // reset state
    #12;
    check("rst_ack", ack, 0);
    check("rst_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_lg", last_grant, 0);
    check("rst_state", dbg_state, 0);
    do_reset();

    // vector table: each entry starts from IDLE, pointer carries over
    vecs[0] = '{1'b1, 2'b01, 8'h41, 8'h00, 2'b01, 1'b1, 8'h41, 1'b1, 3'd0};
    vecs[1] = '{1'b1, 2'b11, 8'h31, 8'h32, 2'b10, 1'b1, 8'h32, 1'b1, 3'd1};
    vecs[2] = '{1'b1, 2'b11, 8'h31, 8'h32, 2'b01, 1'b1, 8'h31, 1'b1, 3'd0};
    vecs[3] = '{1'b0, 2'b10, 8'h00, 8'h55, 2'b00, 1'b0, 8'h31, 1'b0, 3'd0};
    vecs[4] = '{1'b1, 2'b00, 8'h11, 8'h22, 2'b00, 1'b0, 8'h31, 1'b0, 3'd0};
    vecs[5] = '{1'b1, 2'b10, 8'h00, 8'h55, 2'b10, 1'b1, 8'h55, 1'b1, 3'd1};
    vecs[6] = '{1'b1, 2'b10, 8'h00, 8'h66, 2'b10, 1'b1, 8'h66, 1'b1, 3'd1};
    vecs[7] = '{1'b1, 2'b01, 8'hA5, 8'h00, 2'b01, 1'b1, 8'hA5, 1'b1, 3'd0};
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en; req = vecs[i].req; req_data = {vecs[i].d1, vecs[i].d0};
      @(negedge clk);
      check($sformatf("vec%0d_ack", i), ack, vecs[i].e_ack);
      check($sformatf("vec%0d_start", i), tx_start, vecs[i].e_start);
      check($sformatf("vec%0d_data", i), tx_data, vecs[i].e_data);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_lg", i), last_grant, vecs[i].e_lg);
      req = '0;
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // contention: 31,32,31,32 with 13-cycle spacing
    do_reset();
    en = 1'b1; req = 2'b11; req_data = {8'h32, 8'h31}; c0 = cyc; n = 0;
    for (int t = 0; t < 70 && n < 4; t++) begin
      @(negedge clk);
      if (tx_start) begin st[n] = cyc; dt[n] = tx_data; ak[n] = 3'(ack); n++; end
    end
    check("cont_frames", n, 4);
    if (n > 0) check("cont_latency", st[0] - c0, 1);
    for (int i = 0; i < n; i++) begin
      check($sformatf("cont_data%0d", i), dt[i], (i % 2 == 0) ? 8'h31 : 8'h32);
      check($sformatf("cont_ack%0d", i), ak[i], (i % 2 == 0) ? 3'b001 : 3'b010);
      if (i > 0) check($sformatf("cont_gap%0d", i), st[i] - st[i-1], 13);
    end

    // reset right after a grant edge clears outputs before the next edge
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_start", tx_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", tx_data, 8'h00);
    check("midrst_lg", last_grant, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ack", ack, 2'b01);
    check("postrst_start", tx_start, 1);
    check("postrst_data", tx_data, 8'h31);

    // withdrawal: req[1] pulsed during BUSY, dropped before IDLE
    do_reset();
    en = 1'b1; req = 2'b01; req_data = {8'h77, 8'h41};
    last_st = -100; n = 0; a1 = 0;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      if (tx_start) begin
        if (n > 0) check("wd_gap", cyc - last_st, 13);
        check("wd_data", tx_data, 8'h41);
        check("wd_ack", ack, 2'b01);
        last_st = cyc; n++;
      end
      if (ack[1]) a1++;
      since = cyc - last_st;
      req[1] = (since >= 3 && since <= 8);
    end
    check("wd_frames", n, 4);
    check("wd_ack1", a1, 0);

    // enable: en=0 blocks, raising en grants next cycle, dropping mid-frame
    do_reset();
    en = 1'b0; req = 2'b10; req_data = {8'h55, 8'h00}; cnt = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (tx_start || ack != '0) cnt++;
    end
    check("en_blocked", cnt, 0);
    en = 1'b1;
    @(negedge clk);
    check("en_ack", ack, 2'b10);
    check("en_start", tx_start, 1);
    check("en_data", tx_data, 8'h55);
    bc = busy ? 1 : 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (t == 2) begin en = 1'b0; req = '0; end
      if (busy) bc++;
    end
    check("en_busy_len", bc, 12);

    // 3-requester instance: grants 0,1,2,0, spacing 13
    do_reset();
    en_b = 1'b1; req_b = 3'b111; req_data_b = {8'hA2, 8'hA1, 8'hA0}; n = 0;
    for (int t = 0; t < 60 && n < 4; t++) begin
      @(negedge clk);
      if (tx_start_b) begin st[n] = cyc; dt[n] = tx_data_b; ak[n] = last_grant_b; n++; end
    end
    check("n3_frames", n, 4);
    for (int i = 0; i < n; i++) begin
      check($sformatf("n3_lg%0d", i), ak[i], 3'(i % 3));
      check($sformatf("n3_data%0d", i), dt[i], 8'hA0 + 8'(i % 3));
      if (i > 0) check($sformatf("n3_gap%0d", i), st[i] - st[i-1], 13);
    end
    en_b = 1'b0; req_b = '0;

    // randomized traffic against the reference model
    do_reset();
    model_init();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      req = 2'($urandom_range(0, 3));
      req_data = 16'($urandom);
      model_step();
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("rand%0d", i), {ack, tx_start, busy, tx_data, last_grant}, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
